// File: rtl/amm_width_adapter.sv
// Avalon-MM width down-converter: splits each wide master access into per-lane narrow
// sub-accesses, skipping lanes with no enabled bytes, and reassembles read responses.
module amm_width_adapter #(
  parameter int unsigned IN_DW         = 32,
  parameter int unsigned OUT_DW        = 16,
  parameter int unsigned ADDR_W        = 32,
  parameter bit          FORCE_FULL_BE = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [ADDR_W-1:0]                      in_address,
  input  logic                                   in_read,
  input  logic                                   in_write,
  input  logic [IN_DW-1:0]                       in_writedata,
  input  logic [IN_DW/8-1:0]                     in_byteenable,
  output logic [IN_DW-1:0]                       in_readdata,
  output logic                                   in_readdatavalid,
  output logic                                   in_waitrequest,
  output logic [ADDR_W-$clog2(OUT_DW/8)-1:0]     out_address,
  output logic                                   out_read,
  output logic                                   out_write,
  output logic [OUT_DW-1:0]                      out_writedata,
  output logic [OUT_DW/8-1:0]                    out_byteenable,
  input  logic [OUT_DW-1:0]                      out_readdata,
  input  logic                                   out_readdatavalid,
  input  logic                                   out_waitrequest
);

  localparam int unsigned RATIO  = IN_DW / OUT_DW;
  localparam int unsigned IN_BW  = IN_DW / 8;
  localparam int unsigned OUT_BW = OUT_DW / 8;
  localparam int unsigned IN_OFF = $clog2(IN_BW);
  localparam int unsigned OUT_AW = ADDR_W - $clog2(OUT_BW);
  localparam int unsigned BASE_W = ADDR_W - IN_OFF;
  localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned CNT_W  = $clog2(RATIO + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StRdWait, StAck, StResp} state_t;

  state_t              r_state, w_state_d;
  logic [BASE_W-1:0]   r_base;
  logic [IN_DW-1:0]    r_wdata;
  logic [IN_BW-1:0]    r_be;
  logic                r_is_read;
  logic [RATIO-1:0]    r_mask;
  logic [IN_DW-1:0]    r_rdata;
  logic [LANE_W-1:0]   r_lane_fifo [RATIO];
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [CNT_W-1:0]    r_resp_cnt;

  logic [RATIO-1:0]    w_in_mask;
  logic [LANE_W-1:0]   w_lane;
  logic [RATIO-1:0]    w_lane_onehot;
  logic [RATIO-1:0]    w_mask_clr;
  logic [OUT_AW-1:0]   w_out_addr;
  logic [OUT_DW-1:0]   w_out_data;
  logic [OUT_BW-1:0]   w_out_be;
  logic                w_start;
  logic                w_accept;
  logic                w_resp_fire;
  logic [CNT_W-1:0]    w_issue_nxt;
  logic [CNT_W-1:0]    w_resp_nxt;
  logic                w_unused_addr;

  assign w_unused_addr = ^in_address[IN_OFF-1:0];

  always_comb begin
    for (int k = 0; k < RATIO; k++) begin
      w_in_mask[k] = |in_byteenable[k*OUT_BW +: OUT_BW];
    end
  end

  // Lowest pending lane is served first.
  always_comb begin
    w_lane = '0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (r_mask[k]) w_lane = LANE_W'(k);
    end
  end

  always_comb begin
    w_lane_onehot         = '0;
    w_lane_onehot[w_lane] = 1'b1;
  end

  assign w_mask_clr  = r_mask & ~w_lane_onehot;
  assign w_out_addr  = OUT_AW'(r_base) * OUT_AW'(RATIO) + OUT_AW'(w_lane);
  assign w_out_data  = r_wdata[w_lane*OUT_DW +: OUT_DW];
  assign w_out_be    = FORCE_FULL_BE ? {OUT_BW{1'b1}} : r_be[w_lane*OUT_BW +: OUT_BW];

  assign w_start     = (r_state == StIdle) && (in_read || in_write);
  assign w_accept    = (r_state == StCmd) && !out_waitrequest;
  // Responses only count while reads are outstanding for the current transaction.
  assign w_resp_fire = out_readdatavalid && r_is_read && (r_resp_cnt != r_issue_cnt) &&
                       ((r_state == StCmd) || (r_state == StRdWait));
  assign w_issue_nxt = r_issue_cnt + CNT_W'(w_accept && r_is_read);
  assign w_resp_nxt  = r_resp_cnt + CNT_W'(w_resp_fire);

  assign in_readdata = r_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    in_waitrequest   = 1'b1;
    in_readdatavalid = 1'b0;
    out_read         = 1'b0;
    out_write        = 1'b0;
    out_address      = '0;
    out_writedata    = '0;
    out_byteenable   = '0;
    unique case (r_state)
      StIdle: begin
        if (in_read || in_write) begin
          w_state_d = (|w_in_mask) ? StCmd : StAck;
        end
      end
      StCmd: begin
        out_read       = r_is_read;
        out_write      = !r_is_read;
        out_address    = w_out_addr;
        out_writedata  = w_out_data;
        out_byteenable = w_out_be;
        if (w_accept && (w_mask_clr == '0)) begin
          w_state_d = (r_is_read && (w_issue_nxt != w_resp_nxt)) ? StRdWait : StAck;
        end
      end
      StRdWait: begin
        if (w_resp_nxt == r_issue_cnt) w_state_d = StAck;
      end
      StAck: begin
        in_waitrequest = 1'b0;
        w_state_d      = r_is_read ? StResp : StIdle;
      end
      StResp: begin
        in_readdatavalid = 1'b1;
        w_state_d        = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_base      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_is_read   <= 1'b0;
      r_mask      <= '0;
      r_rdata     <= '0;
      r_issue_cnt <= '0;
      r_resp_cnt  <= '0;
      for (int k = 0; k < RATIO; k++) r_lane_fifo[k] <= '0;
    end else if (w_start) begin
      // Read wins if both strobes are raised together.
      r_base      <= in_address[ADDR_W-1:IN_OFF];
      r_wdata     <= in_writedata;
      r_be        <= in_byteenable;
      r_is_read   <= in_read;
      r_mask      <= w_in_mask;
      r_rdata     <= '0;
      r_issue_cnt <= '0;
      r_resp_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_mask <= w_mask_clr;
        if (r_is_read) begin
          r_lane_fifo[LANE_W'(r_issue_cnt)] <= w_lane;
          r_issue_cnt                       <= w_issue_nxt;
        end
      end
      if (w_resp_fire) begin
        r_rdata[r_lane_fifo[LANE_W'(r_resp_cnt)]*OUT_DW +: OUT_DW] <= out_readdata;
        r_resp_cnt <= w_resp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_amm_width_adapter.sv
// Directed bench for amm_width_adapter: a 32->16 instance for the main scenarios and a
// 64->16 instance with forced full byte enables.
module tb_amm_width_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] in_address, in_writedata, in_readdata;
  logic        in_read, in_write, in_readdatavalid, in_waitrequest;
  logic [3:0]  in_byteenable;
  logic [30:0] out_address;
  logic        out_read, out_write, out_readdatavalid, out_waitrequest;
  logic [15:0] out_writedata, out_readdata;
  logic [1:0]  out_byteenable;

  logic [31:0] b_in_address;
  logic [63:0] b_in_writedata, b_in_readdata;
  logic        b_in_read, b_in_write, b_in_readdatavalid, b_in_waitrequest;
  logic [7:0]  b_in_byteenable;
  logic [30:0] b_out_address;
  logic        b_out_read, b_out_write, b_out_readdatavalid, b_out_waitrequest;
  logic [15:0] b_out_writedata, b_out_readdata;
  logic [1:0]  b_out_byteenable;

  int n_checks = 0;
  int n_fail   = 0;

  amm_width_adapter #(
    .IN_DW(32), .OUT_DW(16), .ADDR_W(32), .FORCE_FULL_BE(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_address(in_address), .in_read(in_read), .in_write(in_write),
    .in_writedata(in_writedata), .in_byteenable(in_byteenable),
    .in_readdata(in_readdata), .in_readdatavalid(in_readdatavalid),
    .in_waitrequest(in_waitrequest),
    .out_address(out_address), .out_read(out_read), .out_write(out_write),
    .out_writedata(out_writedata), .out_byteenable(out_byteenable),
    .out_readdata(out_readdata), .out_readdatavalid(out_readdatavalid),
    .out_waitrequest(out_waitrequest)
  );

  amm_width_adapter #(
    .IN_DW(64), .OUT_DW(16), .ADDR_W(32), .FORCE_FULL_BE(1'b1)
  ) dut64 (
    .clk_i(clk), .rst_i(rst),
    .in_address(b_in_address), .in_read(b_in_read), .in_write(b_in_write),
    .in_writedata(b_in_writedata), .in_byteenable(b_in_byteenable),
    .in_readdata(b_in_readdata), .in_readdatavalid(b_in_readdatavalid),
    .in_waitrequest(b_in_waitrequest),
    .out_address(b_out_address), .out_read(b_out_read), .out_write(b_out_write),
    .out_writedata(b_out_writedata), .out_byteenable(b_out_byteenable),
    .out_readdata(b_out_readdata), .out_readdatavalid(b_out_readdatavalid),
    .out_waitrequest(b_out_waitrequest)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    in_address = '0; in_read = 1'b0; in_write = 1'b0; in_writedata = '0; in_byteenable = '0;
    out_readdata = '0; out_readdatavalid = 1'b0; out_waitrequest = 1'b0;
    b_in_address = '0; b_in_read = 1'b0; b_in_write = 1'b0; b_in_writedata = '0;
    b_in_byteenable = '0; b_out_readdata = '0; b_out_readdatavalid = 1'b0;
    b_out_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_waitrequest, in_readdatavalid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_in_ctrl: got %b want 10", {in_waitrequest, in_readdatavalid});
    end
    n_checks++;
    if (in_readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata: got %h want 0", in_readdata);
    end
    n_checks++;
    if ({out_read, out_write, out_address, out_writedata, out_byteenable} !== '0) begin
      n_fail++; $display("FAIL reset_out: got %b%b %h %h %h want all 0",
                         out_read, out_write, out_address, out_writedata, out_byteenable);
    end
    n_checks++;
    if (b_in_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL reset_wide_wait: got %b want 1", b_in_waitrequest);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_waitrequest, out_read, out_write} !== 3'b100) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 100",
                         {in_waitrequest, out_read, out_write});
    end
  endtask

  task automatic test_write_full();
    in_address = 32'h10; in_writedata = 32'hAABBCCDD; in_byteenable = 4'hF; in_write = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_write, out_read, out_address, out_writedata, out_byteenable, in_waitrequest} !==
        {1'b1, 1'b0, 31'h8, 16'hCCDD, 2'h3, 1'b1}) begin
      n_fail++; $display("FAIL wr_full_lane0: got w%b r%b a%h d%h be%h wait%b want w1 r0 a8 dccdd be3 wait1",
                         out_write, out_read, out_address, out_writedata, out_byteenable,
                         in_waitrequest);
    end
    @(negedge clk);
    n_checks++;
    if ({out_write, out_address, out_writedata, out_byteenable, in_waitrequest} !==
        {1'b1, 31'h9, 16'hAABB, 2'h3, 1'b1}) begin
      n_fail++; $display("FAIL wr_full_lane1: got w%b a%h d%h be%h wait%b want w1 a9 daabb be3 wait1",
                         out_write, out_address, out_writedata, out_byteenable, in_waitrequest);
    end
    @(negedge clk);
    n_checks++;
    if ({in_waitrequest, out_write} !== 2'b00) begin
      n_fail++; $display("FAIL wr_full_ack_cycle3: got wait%b w%b want wait0 w0",
                         in_waitrequest, out_write);
    end
    @(negedge clk);
    n_checks++;
    if ({in_waitrequest, in_readdatavalid} !== 2'b10) begin
      n_fail++; $display("FAIL wr_full_idle: got %b want 10", {in_waitrequest, in_readdatavalid});
    end
    in_write = 1'b0;
  endtask

  task automatic test_write_partial();
    in_address = 32'h10; in_writedata = 32'h12340000; in_byteenable = 4'hC; in_write = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_write, out_address, out_writedata, out_byteenable} !==
        {1'b1, 31'h9, 16'h1234, 2'h3}) begin
      n_fail++; $display("FAIL wr_skip_lane1: got w%b a%h d%h be%h want w1 a9 d1234 be3",
                         out_write, out_address, out_writedata, out_byteenable);
    end
    @(negedge clk);
    n_checks++;
    if ({in_waitrequest, out_write} !== 2'b00) begin
      n_fail++; $display("FAIL wr_skip_ack: got wait%b w%b want wait0 w0",
                         in_waitrequest, out_write);
    end
    @(negedge clk);
    in_write = 1'b0;
  endtask

  task automatic test_read_stall();
    in_address = 32'h4; in_byteenable = 4'hF; in_read = 1'b1; out_waitrequest = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_read, out_write, out_address, out_byteenable, in_waitrequest} !==
        {1'b1, 1'b0, 31'h2, 2'h3, 1'b1}) begin
      n_fail++; $display("FAIL rd_lane0: got r%b w%b a%h be%h wait%b want r1 w0 a2 be3 wait1",
                         out_read, out_write, out_address, out_byteenable, in_waitrequest);
    end
    @(negedge clk);
    n_checks++;
    if ({out_read, out_address} !== {1'b1, 31'h3}) begin
      n_fail++; $display("FAIL rd_lane1: got r%b a%h want r1 a3", out_read, out_address);
    end
    out_waitrequest = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_read, out_address, out_byteenable} !== {1'b1, 31'h3, 2'h3}) begin
      n_fail++; $display("FAIL rd_lane1_stall_hold: got r%b a%h be%h want r1 a3 be3",
                         out_read, out_address, out_byteenable);
    end
    out_waitrequest = 1'b0; out_readdatavalid = 1'b1; out_readdata = 16'h5678;
    @(negedge clk);
    n_checks++;
    if ({out_read, in_waitrequest} !== 2'b01) begin
      n_fail++; $display("FAIL rd_wait_state: got r%b wait%b want r0 wait1", out_read, in_waitrequest);
    end
    out_readdatavalid = 1'b0; out_readdata = 16'hDEAD;
    @(negedge clk);
    out_readdatavalid = 1'b1; out_readdata = 16'h9ABC;
    @(negedge clk);
    n_checks++;
    if ({in_waitrequest, in_readdatavalid} !== 2'b00) begin
      n_fail++; $display("FAIL rd_ack: got wait%b rdv%b want wait0 rdv0",
                         in_waitrequest, in_readdatavalid);
    end
    // Stray response during ACK must not disturb the assembled word.
    out_readdatavalid = 1'b1; out_readdata = 16'hFFFF;
    @(negedge clk);
    out_readdatavalid = 1'b0;
    n_checks++;
    if ({in_readdatavalid, in_readdata, in_waitrequest} !== {1'b1, 32'h9ABC5678, 1'b1}) begin
      n_fail++; $display("FAIL rd_resp: got rdv%b d%h wait%b want rdv1 d9abc5678 wait1",
                         in_readdatavalid, in_readdata, in_waitrequest);
    end
    in_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_resp_single_pulse: got %b want 0", in_readdatavalid);
    end
  endtask

  task automatic test_read_empty();
    in_address = 32'h40; in_byteenable = 4'h0; in_read = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_waitrequest, out_read, out_write} !== 3'b000) begin
      n_fail++; $display("FAIL rd_empty_ack: got wait%b r%b w%b want 000",
                         in_waitrequest, out_read, out_write);
    end
    @(negedge clk);
    n_checks++;
    if ({in_readdatavalid, in_readdata, out_read} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL rd_empty_resp: got rdv%b d%h r%b want rdv1 d00000000 r0",
                         in_readdatavalid, in_readdata, out_read);
    end
    in_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_empty_pulse: got %b want 0", in_readdatavalid);
    end
  endtask

  task automatic test_wide_force_be();
    for (int i = 0; i < 2; i++) begin
      b_in_address = 32'h20; b_in_writedata = 64'h0000_1111_2222_3333;
      b_in_byteenable = (i == 0) ? 8'h30 : 8'h10; b_in_write = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({b_out_write, b_out_address, b_out_writedata, b_out_byteenable} !==
          {1'b1, 31'h12, 16'h1111, 2'h3}) begin
        n_fail++; $display("FAIL wide_lane2_be%h: got w%b a%h d%h be%h want w1 a12 d1111 be3",
                           b_in_byteenable, b_out_write, b_out_address, b_out_writedata,
                           b_out_byteenable);
      end
      @(negedge clk);
      n_checks++;
      if ({b_in_waitrequest, b_out_write} !== 2'b00) begin
        n_fail++; $display("FAIL wide_ack_be%h: got wait%b w%b want 00",
                           b_in_byteenable, b_in_waitrequest, b_out_write);
      end
      @(negedge clk);
      b_in_write = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    in_address = 32'h0; in_byteenable = 4'hF; in_read = 1'b1; out_waitrequest = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_read !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_cmd: got r%b want 1", out_read);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_read, out_write, in_waitrequest} !== 3'b001) begin
      n_fail++; $display("FAIL mid_rst_async_drop: got r%b w%b wait%b want 001",
                         out_read, out_write, in_waitrequest);
    end
    in_read = 1'b0;
    @(negedge clk);
    rst = 1'b0; out_waitrequest = 1'b0; out_readdatavalid = 1'b1; out_readdata = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({in_readdatavalid, in_readdata} !== {1'b0, 32'h0}) begin
        n_fail++; $display("FAIL mid_rst_ignore_resp%0d: got rdv%b d%h want rdv0 d0",
                           i, in_readdatavalid, in_readdata);
      end
    end
    out_readdatavalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_write_partial();
    test_read_stall();
    test_read_empty();
    test_wide_force_be();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
